// File: rtl/regfile_dump_unit.sv
// regfile_dump_unit
// Walks every register of the register file through one combinational read
// port and streams (index, data) pairs over a valid/ready handshake.
// Each register takes one READ cycle (address out, data captured) followed
// by one or more SEND cycles (held until the consumer accepts it).

module regfile_dump_unit #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_add,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_index,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_READ   = 2'd1;
    localparam logic [1:0] S_SEND   = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    // Terminal index is compared explicitly; the counter never wraps.
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] r_out_index;
    logic [DATA_W-1:0] r_out_data;

    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic              w_accept;
    logic              w_last;

    // A transfer offered in the same cycle as abort does not count as accepted.
    assign w_accept = (r_state == S_SEND) && out_ready && !abort;
    assign w_last   = (r_cnt == LAST_IDX);

    // Next-state and counter update; abort overrides everything while busy.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_state_nxt = S_READ;
                    w_cnt_nxt   = '0;
                end
            end
            S_READ: begin
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                if (w_accept) begin
                    if (w_last) begin
                        w_state_nxt = S_FINISH;
                    end else begin
                        w_state_nxt = S_READ;
                        w_cnt_nxt   = r_cnt + ADDR_W'(1);
                    end
                end
            end
            S_FINISH: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        if (abort && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end
    end

    // State and index counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Capture the register value at the end of READ; held through SEND so the
    // consumer sees stable data under backpressure without a re-read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_index <= '0;
            r_out_data  <= '0;
        end else if ((r_state == S_READ) && !abort) begin
            r_out_index <= r_cnt;
            r_out_data  <= rd_data;
        end
    end

    // The read address is the registered counter: valid in READ, holds the
    // same index through SEND, and returns to 0 once the dump ends.
    assign rd_add    = r_cnt;
    assign out_index = r_out_index;
    assign out_data  = r_out_data;
    assign out_valid = (r_state == S_SEND);
    assign done      = (r_state == S_FINISH);
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_regfile_dump_unit.sv
// Directed bench for regfile_dump_unit with a behavioural register file.
module tb_regfile_dump_unit;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] rd_add;
    logic [DW-1:0] rd_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] out_index;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] regs [32];
    logic [AW-1:0] q_idx [$];
    logic [DW-1:0] q_dat [$];
    int            done_cnt = 0;

    logic          p_v = 1'b0;
    logic          p_r = 1'b0;
    logic [AW-1:0] p_i = '0;
    logic [DW-1:0] p_d = '0;

    regfile_dump_unit #(.NUM_REGS(32), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .rd_add    (rd_add),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Register file: r0 always reads as zero.
    always_comb begin
        rd_data = (rd_add == '0) ? '0 : regs[rd_add];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Monitor at the falling edge: log accepted transfers, count done pulses,
    // check hold-under-backpressure and done/out_valid exclusivity.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (done && out_valid) chk("done_and_valid", 32'd1, 32'd0);
            if (p_v && !p_r && out_valid) begin
                chk("hold_idx", 32'(out_index), 32'(p_i));
                chk("hold_dat", out_data, p_d);
            end
            if (out_valid && out_ready && !abort) begin
                q_idx.push_back(out_index);
                q_dat.push_back(out_data);
            end
        end
        p_v = out_valid && rst_n;
        p_r = out_ready;
        p_i = out_index;
        p_d = out_data;
    end

    // Start a dump and run until done (or budget expires). dcyc = cycle of
    // done counted from the start edge, -1 if it never came.
    task automatic run_dump(input int pct, input bit pulses, output int dcyc);
        int n;
        q_idx.delete();
        q_dat.delete();
        done_cnt = 0;
        dcyc = -1;
        out_ready = ($urandom_range(0, 99) < pct);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        while (n < 3000) begin
            if (done) begin
                dcyc = n;
                break;
            end
            out_ready = ($urandom_range(0, 99) < pct);
            start = pulses && (n % 5 == 0);
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        if (dcyc < 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    // Post-dump checks: busy with done, busy falls after, single done pulse,
    // and the full ordered list of 32 pairs.
    task automatic check_dump(input string tag, input int dcyc, input int exp_cyc);
        if (exp_cyc > 0) chk({tag, "_done_cyc"}, 32'(dcyc), 32'(exp_cyc));
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk({tag, "_done_after"}, 32'(done), 32'd0);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        chk({tag, "_rd_add_after"}, 32'(rd_add), 32'd0);
        chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        chk({tag, "_n_xfer"}, 32'(q_idx.size()), 32'd32);
        for (int k = 0; k < 32 && k < q_idx.size(); k++) begin
            chk($sformatf("%s_idx%0d", tag, k), 32'(q_idx[k]), 32'(k));
            chk($sformatf("%s_dat%0d", tag, k), q_dat[k],
                (k == 0) ? 32'h0 : (32'hA5A50000 + 32'(k)));
        end
    endtask

    initial begin
        int dc;
        int n;
        for (int k = 0; k < 32; k++) regs[k] = 32'hA5A50000 + 32'(k);

        // Reset state
        #12;
        chk("rst_rd_add", 32'(rd_add), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_index", 32'(out_index), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full dump with out_ready tied high: done lands in cycle 65
        run_dump(100, 1'b0, dc);
        check_dump("full", dc, 65);

        // Random backpressure (~30% ready)
        run_dump(30, 1'b0, dc);
        check_dump("rand", dc, -1);

        // Abort while index 10 is presented and not accepted
        q_idx.delete();
        q_dat.delete();
        done_cnt = 0;
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!(out_valid && out_index == 5'd10) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("abort_wait_timeout", 32'd0, 32'd1);
        out_ready = 1'b0;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_rd_add", 32'(rd_add), 32'd0);
        chk("abort_n_xfer", 32'(q_idx.size()), 32'd10);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        chk("abort_stay_idle", 32'(busy), 32'd0);

        // Restart after abort begins at index 0
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_rd_add", 32'(rd_add), 32'd0);
        @(posedge clk); #1;
        chk("restart_valid", 32'(out_valid), 32'd1);
        chk("restart_idx", 32'(out_index), 32'd0);
        chk("restart_dat", out_data, 32'd0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;

        // Start pulsed during a dump is ignored
        run_dump(100, 1'b1, dc);
        check_dump("pulse", dc, 65);

        // start with abort in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        chk("sa_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy2", 32'(busy), 32'd0);
        chk("sa_rd_add", 32'(rd_add), 32'd0);

        // Asynchronous reset mid-dump, away from any clock edge
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rd_add", 32'(rd_add), 32'd0);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_index", 32'(out_index), 32'd0);
        chk("arst_data", out_data, 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            chk("post_rst_busy", 32'(busy), 32'd0);
            chk("post_rst_valid", 32'(out_valid), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_dump_unit.md
# regfile_dump_unit

Sequential read-out engine that walks every register of the 32 x 32-bit register file through one of the file's combinational read ports. It streams each register to a debug or trace consumer as an (index, data) pair over a valid/ready handshake. It sits beside the register file in the single-cycle datapath: it acts as a reader on the file's read-address/read-data interface and as the source side of an output stream.

## Interface
Parameters:
- NUM_REGS, 32, number of registers walked (indices 0..NUM_REGS-1)
- ADDR_W, 5, register address width
- DATA_W, 32, register data width

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request a dump; sampled only in IDLE
- abort  input  1  cancel a dump in progress
- rd_add  output  ADDR_W  read address driven to a register-file read port
- rd_data  input  DATA_W  read data returned combinationally by the register file for rd_add
- out_valid  output  1  out_index/out_data hold a register value
- out_ready  input  1  consumer accepts when out_valid && out_ready at a rising edge
- out_index  output  ADDR_W  index of the register being presented
- out_data  output  DATA_W  captured register value
- busy  output  1  dump in progress
- done  output  1  one-cycle pulse after the last register is accepted

## Operation
- States: IDLE, READ, SEND, FINISH.
- Reset (async, rst_n=0): state=IDLE, index counter=0.
  - Outputs: rd_add=0, out_valid=0, out_index=0, out_data=0, busy=0, done=0.
- IDLE:
  - start=1 && abort=0 -> READ, counter=0.
  - Otherwise stay in IDLE.
- READ:
  - rd_add = counter.
  - At the edge: out_data <= rd_data, out_index <= counter -> SEND.
- SEND:
  - out_valid=1; out_index/out_data held stable until accepted.
  - Acceptance with counter != NUM_REGS-1: counter+1 -> READ.
  - Acceptance with counter == NUM_REGS-1: -> FINISH.
- FINISH: done=1 for exactly one cycle -> IDLE; counter and rd_add return to 0.
- busy=1 in READ, SEND and FINISH.
- abort=1 in READ/SEND/FINISH -> IDLE at the next edge.
  - out_valid drops, no done pulse, counter=0.
  - A transfer offered in the same cycle as abort is NOT counted as accepted.
- start while busy: ignored.
- start and abort together in IDLE: abort wins, stay IDLE.
- Register 0: passes through whatever rd_data returns (the register file returns 0). The block applies no special case.
- Counter is ADDR_W bits and never wraps: the terminal index is compared explicitly.
- rd_add is registered; it is only meaningful in READ. It holds the counter value in SEND.

## Timing
- Start accepted at edge E0 -> READ during cycle 1 (rd_add=0).
  - Edge E1 captures the value -> out_valid=1 in cycle 2.
- Per register: 1 READ cycle + >=1 SEND cycle.
  - With out_ready tied high: 2 cycles per register.
  - Full dump: 64 cycles plus 1 FINISH cycle; done is high in cycle 65 after start.
- out_ready backpressure stalls in SEND indefinitely; no data loss and no re-read.
- Register-file writes during a dump: the value captured is the one present at the READ edge. No coherence beyond that.
- The register file's read is combinational on address change. rd_data must settle within the READ cycle; no extra wait state.
- done and out_valid are never high in the same cycle.

## Test plan
- Preload register k = 0xA5A50000+k; start with out_ready=1.
  - 32 transfers: index 0 data 0x00000000 (register file zeroes r0), index 1 data 0xA5A50001 ... index 31 data 0xA5A5001F.
  - done is a single pulse at cycle 65 after start; busy falls with it.
- Random out_ready (about 30% high): same 32 pairs in order.
  - out_index/out_data are stable while out_valid=1 and out_ready=0; no duplicates.
- abort while waiting to present index 10, out_ready=0:
  - next cycle out_valid=0, busy=0, no done.
  - A new start restarts at index 0.
- Pulse start repeatedly during a dump and assert start with abort in IDLE:
  - no restart and no extra transfers; abort wins in IDLE.
- Deassert rst_n asynchronously mid-dump (no clock edge):
  - all outputs go to 0 immediately; state stays IDLE after release until start.
